// File: rtl/play_sequencer.sv
// play_sequencer: walks a step index through an external track ROM and drives note/gate/step timing.
// Latency: all outputs registered; step period = unit cycles + FETCH cycles (minimum 1 FETCH cycle).
// Backpressure: rom_req held until rom_valid; build macro PLAY_SEQUENCER_LOOP_EN loops the song instead of ending in DONE.
module play_sequencer #(
  parameter int unsigned UNIT_CYCLES_0  = 5000000,
  parameter int unsigned DELAY_CYCLES_0 = 52083,
  parameter int unsigned UNIT_CYCLES_1  = 7812500,
  parameter int unsigned DELAY_CYCLES_1 = 65104,
  parameter int unsigned SONG_LEN       = 1540,
  parameter int unsigned ADDR_W         = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        track_choose,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_stop,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [7:0]        rom_data,
  output logic [7:0]        note_out,
  output logic              gate,
  output logic              step_pulse,
  output logic [ADDR_W-1:0] cur_step,
  output logic [1:0]        track_sel,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_GAP, S_HOLD, S_PAUSED, S_DONE} state_t;

  localparam logic [31:0]       UNIT0_M1  = 32'(UNIT_CYCLES_0 - 1);
  localparam logic [31:0]       DELAY0_M1 = 32'(DELAY_CYCLES_0 - 1);
  localparam logic [31:0]       UNIT1_M1  = 32'(UNIT_CYCLES_1 - 1);
  localparam logic [31:0]       DELAY1_M1 = 32'(DELAY_CYCLES_1 - 1);
  localparam logic [ADDR_W-1:0] SONG_END  = ADDR_W'(SONG_LEN);

  state_t            state_q, state_d;
  state_t            resume_q, resume_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       unit_m1_q, unit_m1_d;
  logic [31:0]       delay_m1_q, delay_m1_d;
  logic [ADDR_W-1:0] step_q, step_d, step_inc;
  logic [7:0]        byte_q, byte_d;
  logic [1:0]        track_q, track_d;
  logic              gate_q, gate_d;
  logic [7:0]        note_q, note_d;
  logic              sp_q, sp_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;

  // Register all state and every output together so outputs line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      resume_q   <= S_GAP;
      cnt_q      <= '0;
      unit_m1_q  <= '0;
      delay_m1_q <= '0;
      step_q     <= '0;
      byte_q     <= '0;
      track_q    <= '0;
      gate_q     <= 1'b0;
      note_q     <= '0;
      sp_q       <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      cnt_q      <= cnt_d;
      unit_m1_q  <= unit_m1_d;
      delay_m1_q <= delay_m1_d;
      step_q     <= step_d;
      byte_q     <= byte_d;
      track_q    <= track_d;
      gate_q     <= gate_d;
      note_q     <= note_d;
      sp_q       <= sp_d;
      done_q     <= done_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
    end
  end

  // Next state and next output values; stop beats pause, pause beats start and the step counter.
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    cnt_d      = cnt_q;
    unit_m1_d  = unit_m1_q;
    delay_m1_d = delay_m1_q;
    step_d     = step_q;
    byte_d     = byte_q;
    track_d    = track_q;
    sp_d       = 1'b0;
    done_d     = 1'b0;
    step_inc   = step_q + 1'b1;

    if (cmd_stop) begin
      state_d = S_IDLE;
      step_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cmd_start) begin
            track_d    = track_choose;
            unit_m1_d  = (track_choose == 2'd0) ? UNIT0_M1 : UNIT1_M1;
            delay_m1_d = (track_choose == 2'd0) ? DELAY0_M1 : DELAY1_M1;
            step_d     = '0;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: begin
          // Pause is not honoured here; the byte must land first.
          if (rom_valid) begin
            byte_d  = rom_data;
            cnt_d   = '0;
            sp_d    = 1'b1;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (cmd_pause) begin
            resume_d = S_GAP;
            state_d  = S_PAUSED;
          end else begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == delay_m1_q) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cmd_pause) begin
            resume_d = S_HOLD;
            state_d  = S_PAUSED;
          end else if (cnt_q == unit_m1_q) begin
            step_d = step_inc;
            if (step_inc == SONG_END) begin
              done_d = 1'b1;
`ifdef PLAY_SEQUENCER_LOOP_EN
              step_d  = '0;
              state_d = S_FETCH;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_PAUSED: begin
          if (!cmd_pause && cmd_start) state_d = resume_q;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Gate and note follow the state being entered; FETCH keeps the previous note sounding.
    gate_d = gate_q;
    note_d = note_q;
    case (state_d)
      S_FETCH: begin
        gate_d = gate_q;
        note_d = note_q;
      end
      S_GAP: begin
        gate_d = byte_d[7] && (byte_d[6:0] != 7'd0);
        note_d = {1'b0, byte_d[6:0]};
      end
      S_HOLD: begin
        gate_d = (byte_d[6:0] != 7'd0);
        note_d = {1'b0, byte_d[6:0]};
      end
      S_PAUSED: begin
        gate_d = 1'b0;
        note_d = {1'b0, byte_d[6:0]};
      end
      default: begin
        gate_d = 1'b0;
        note_d = '0;
      end
    endcase

    req_d  = (state_d == S_FETCH);
    busy_d = (state_d == S_FETCH) || (state_d == S_GAP) ||
             (state_d == S_HOLD)  || (state_d == S_PAUSED);
  end

  assign rom_req    = req_q;
  assign rom_addr   = step_q;
  assign cur_step   = step_q;
  assign note_out   = note_q;
  assign gate       = gate_q;
  assign step_pulse = sp_q;
  assign track_sel  = track_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_play_sequencer.sv
// tb_play_sequencer: directed scenarios against play_sequencer with a small latency-programmable ROM model.
// Short tempo constants (20/4, 30/5, 3 steps) keep every scenario to a few dozen cycles.
// Outputs are sampled on the falling edge; inputs are driven there too.
module tb_play_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  track_choose;
  logic        cmd_start;
  logic        cmd_pause;
  logic        cmd_stop;
  logic        rom_req;
  logic [10:0] rom_addr;
  logic        rom_valid = 1'b0;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  note_out;
  logic        gate;
  logic        step_pulse;
  logic [10:0] cur_step;
  logic [1:0]  track_sel;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  play_sequencer #(
    .UNIT_CYCLES_0(20), .DELAY_CYCLES_0(4),
    .UNIT_CYCLES_1(30), .DELAY_CYCLES_1(5),
    .SONG_LEN(3), .ADDR_W(11)
  ) dut (
    .clk(clk), .rst(rst), .track_choose(track_choose),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_valid(rom_valid), .rom_data(rom_data),
    .note_out(note_out), .gate(gate), .step_pulse(step_pulse), .cur_step(cur_step),
    .track_sel(track_sel), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1, "watchdog expired");
  end

  // ROM model: valid (with data) arrives rom_lat cycles after rom_req rises.
  logic [7:0] rom [0:3];
  int rom_lat = 1;
  int req_age = 0;
  always @(negedge clk) begin
    if (rom_req) begin
      if (req_age == rom_lat) begin
        rom_valid = 1'b1;
        rom_data  = rom[rom_addr[1:0]];
      end else begin
        rom_valid = 1'b0;
      end
      req_age = req_age + 1;
    end else begin
      rom_valid = 1'b0;
      req_age   = 0;
    end
  end

  typedef struct packed {
    logic        gate;
    logic        sp;
    logic        done;
    logic        busy;
    logic        req;
    logic [7:0]  note;
    logic [10:0] step;
    logic [10:0] addr;
  } obs_t;
  obs_t cap [0:127];

  function automatic int first_sp(input int from, input int upto);
    for (int i = from; i <= upto; i++) if (cap[i].sp) return i;
    return -1;
  endfunction

  function automatic int gate_high(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap[i].gate) n++;
    return n;
  endfunction

  function automatic int req_high(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap[i].req) n++;
    return n;
  endfunction

  function automatic int done_cnt(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap[i].done) n++;
    return n;
  endfunction

  function automatic int addr_diff(input int lo, input int hi, input logic [10:0] a);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (cap[i].addr !== a) n++;
    return n;
  endfunction

  task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    rom[0] = b0; rom[1] = b1; rom[2] = b2; rom[3] = 8'h00;
  endtask

  // Pulse start, then record n falling-edge samples; optional pause/resume pulses and track_choose change.
  task automatic run(input int n, input int pause_at, input int resume_at, input logic [1:0] choose_after);
    cmd_start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      cap[i] = '{gate: gate, sp: step_pulse, done: done, busy: busy, req: rom_req,
                 note: note_out, step: cur_step, addr: rom_addr};
      cmd_start = (i == resume_at);
      cmd_pause = (i == pause_at);
      if (i == 1) track_choose = choose_after;
    end
    cmd_start = 1'b0;
    cmd_pause = 1'b0;
  endtask

  task automatic do_stop();
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({rom_req, rom_addr, note_out, gate, step_pulse, cur_step, track_sel, busy, done} !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs: req=%0d addr=%0d note=%0h gate=%0d sp=%0d step=%0d trk=%0d busy=%0d done=%0d want all 0",
               rom_req, rom_addr, note_out, gate, step_pulse, cur_step, track_sel, busy, done);
    end
  endtask

  task automatic test_basic_play();
    int v;
    load_rom(8'h45, 8'hC5, 8'h00);
    rom_lat = 1;
    track_choose = 2'd0;
    run(70, -1, -1, 2'd0);
    v = first_sp(1, 70);
    checks++; if (v !== 3) begin failures++; $display("FAIL basic_sp0: got %0d want 3", v); end
    v = first_sp(4, 70);
    checks++; if (v !== 25) begin failures++; $display("FAIL basic_period: sp1 at %0d want 25", v); end
    v = first_sp(26, 70);
    checks++; if (v !== 47) begin failures++; $display("FAIL basic_sp2: got %0d want 47", v); end
    v = gate_high(3, 6);
    checks++; if (v !== 0) begin failures++; $display("FAIL basic_gap: gate high %0d cycles want 0", v); end
    v = gate_high(7, 22);
    checks++; if (v !== 16) begin failures++; $display("FAIL basic_hold: gate high %0d want 16", v); end
    v = gate_high(23, 46);
    checks++; if (v !== 24) begin failures++; $display("FAIL basic_tie: gate high %0d want 24", v); end
    v = gate_high(47, 70);
    checks++; if (v !== 0) begin failures++; $display("FAIL basic_rest: gate high %0d want 0", v); end
    checks++; if (cap[10].note !== 8'h45) begin failures++; $display("FAIL basic_note0: got %0h want 45", cap[10].note); end
    checks++; if (cap[30].note !== 8'h45) begin failures++; $display("FAIL basic_note1: got %0h want 45", cap[30].note); end
    v = done_cnt(1, 70);
    checks++; if (v !== 1 || cap[67].done !== 1'b1) begin
      failures++; $display("FAIL basic_done: count %0d at67=%0d want 1/1", v, cap[67].done);
    end
`ifdef PLAY_SEQUENCER_LOOP_EN
    checks++; if (cap[67].step !== 11'd0 || cap[68].busy !== 1'b1) begin
      failures++; $display("FAIL loop_wrap: step=%0d busy=%0d want 0/1", cap[67].step, cap[68].busy);
    end
`else
    checks++; if (cap[68].busy !== 1'b0) begin failures++; $display("FAIL basic_idle_done: busy=%0d want 0", cap[68].busy); end
`endif
    do_stop();
  endtask

  task automatic test_track_select();
    int v;
    load_rom(8'h45, 8'h45, 8'h45);
    track_choose = 2'd2;
    run(40, -1, -1, 2'd0);
    checks++; if (track_sel !== 2'd2) begin failures++; $display("FAIL track_latched: got %0d want 2", track_sel); end
    v = first_sp(4, 40);
    checks++; if (v !== 35) begin failures++; $display("FAIL track_period: sp1 at %0d want 35", v); end
    v = gate_high(3, 7);
    checks++; if (v !== 0 || cap[8].gate !== 1'b1) begin
      failures++; $display("FAIL track_gap: gap high %0d first hold gate %0d want 0/1", v, cap[8].gate);
    end
    do_stop();
  endtask

  task automatic test_pause_resume();
    int v;
    load_rom(8'h45, 8'h45, 8'h45);
    track_choose = 2'd0;
    run(80, 13, 63, 2'd0);
    checks++; if (cap[13].gate !== 1'b1) begin failures++; $display("FAIL pause_pre: gate=%0d want 1", cap[13].gate); end
    v = gate_high(14, 63);
    checks++; if (v !== 0) begin failures++; $display("FAIL pause_gate: gate high %0d want 0", v); end
    checks++; if (cap[40].step !== 11'd0 || cap[40].busy !== 1'b1 || cap[40].note !== 8'h45) begin
      failures++; $display("FAIL pause_frozen: step=%0d busy=%0d note=%0h want 0/1/45", cap[40].step, cap[40].busy, cap[40].note);
    end
    checks++; if (cap[64].gate !== 1'b1) begin failures++; $display("FAIL resume_gate: got %0d want 1", cap[64].gate); end
    checks++; if (cap[73].req !== 1'b0 || cap[74].req !== 1'b1 || cap[74].step !== 11'd1) begin
      failures++; $display("FAIL resume_len: req73=%0d req74=%0d step74=%0d want 0/1/1", cap[73].req, cap[74].req, cap[74].step);
    end
    v = first_sp(4, 80);
    checks++; if (v !== 76) begin failures++; $display("FAIL resume_sp: got %0d want 76", v); end
    do_stop();
  endtask

  task automatic test_stop_in_fetch();
    load_rom(8'h45, 8'h45, 8'h45);
    track_choose = 2'd0;
    run(24, -1, -1, 2'd0);
    checks++; if (cap[24].req !== 1'b1 || cap[24].step !== 11'd1) begin
      failures++; $display("FAIL stop_pre: req=%0d step=%0d want 1/1", cap[24].req, cap[24].step);
    end
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    checks++; if ({busy, step_pulse, rom_req, gate} !== 4'b0000 || cur_step !== 11'd0 || note_out !== 8'h00) begin
      failures++; $display("FAIL stop_fetch: busy=%0d sp=%0d req=%0d gate=%0d step=%0d note=%0h want all 0",
                           busy, step_pulse, rom_req, gate, cur_step, note_out);
    end
    @(negedge clk);
    checks++; if ({busy, step_pulse} !== 2'b00) begin
      failures++; $display("FAIL stop_after: busy=%0d sp=%0d want 0/0", busy, step_pulse);
    end
  endtask

  task automatic test_slow_rom();
    int v;
    load_rom(8'h45, 8'h45, 8'h45);
    rom_lat = 7;
    track_choose = 2'd0;
    run(40, -1, -1, 2'd0);
    v = req_high(1, 8);
    checks++; if (v !== 8 || cap[9].req !== 1'b0) begin
      failures++; $display("FAIL slow_req: high %0d req9=%0d want 8/0", v, cap[9].req);
    end
    v = addr_diff(1, 8, 11'd0) + addr_diff(29, 36, 11'd1);
    checks++; if (v !== 0) begin failures++; $display("FAIL slow_addr: %0d unstable samples want 0", v); end
    v = first_sp(10, 40);
    checks++; if (v !== 37 || cap[9].sp !== 1'b1) begin
      failures++; $display("FAIL slow_period: sp1 at %0d sp0=%0d want 37/1", v, cap[9].sp);
    end
    do_stop();
    rom_lat = 1;
  endtask

  task automatic test_start_stop_same();
    cmd_start = 1'b1;
    cmd_stop  = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    checks++; if ({busy, rom_req} !== 2'b00) begin
      failures++; $display("FAIL start_stop: busy=%0d req=%0d want 0/0", busy, rom_req);
    end
  endtask

  task automatic test_reset_mid_hold();
    load_rom(8'h45, 8'h45, 8'h45);
    track_choose = 2'd3;
    run(10, -1, -1, 2'd3);
    checks++; if (cap[10].gate !== 1'b1 || track_sel !== 2'd3) begin
      failures++; $display("FAIL rst_pre: gate=%0d trk=%0d want 1/3", cap[10].gate, track_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({rom_req, rom_addr, note_out, gate, step_pulse, cur_step, track_sel, busy, done} !== 36'd0) begin
      failures++; $display("FAIL rst_hold: req=%0d addr=%0d note=%0h gate=%0d sp=%0d step=%0d trk=%0d busy=%0d done=%0d want all 0",
                           rom_req, rom_addr, note_out, gate, step_pulse, cur_step, track_sel, busy, done);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_start = 1'b0;
    cmd_pause = 1'b0;
    cmd_stop  = 1'b0;
    track_choose = 2'd0;
    load_rom(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_play();
    test_track_select();
    test_pause_resume();
    test_stop_in_fetch();
    test_slow_rom();
    test_start_stop_same();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
